// File: rtl/spu_pipe_pkg.sv
// Shared definitions for the SPU result-staging pipeline.
//   - Producing-unit id constants.
//   - Entry layout helpers. An entry is {valid, unit, data, dst, lat, wr},
//     MSB first, so every field offset depends on DW/AW/LW.
package spu_pipe_pkg;

  localparam logic [2:0] UNIT_PERM = 3'b101;
  localparam logic [2:0] UNIT_LS   = 3'b110;
  localparam logic [2:0] UNIT_BR   = 3'b111;

  localparam int UNIT_W = 3;

  // Total entry width for a given data/address/latency width.
  function automatic int ENTRY_W(input int dw, input int aw, input int lw);
    return 1 + UNIT_W + dw + aw + lw + 1;
  endfunction

  // Field offsets (LSB position of each field inside an entry).
  localparam int OFF_WR  = 0;
  localparam int OFF_LAT = 1;

  function automatic int OFF_DST(input int lw);
    return OFF_LAT + lw;
  endfunction

  function automatic int OFF_DATA(input int aw, input int lw);
    return OFF_DST(lw) + aw;
  endfunction

  function automatic int OFF_UNIT(input int dw, input int aw, input int lw);
    return OFF_DATA(aw, lw) + dw;
  endfunction

  function automatic int OFF_VALID(input int dw, input int aw, input int lw);
    return OFF_UNIT(dw, aw, lw) + UNIT_W;
  endfunction

endpackage

// File: rtl/spu_pipe_stage.sv
// One staging register of the SPU result pipeline.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous reset, active-high (clears the entry)
//   d      in   entry to capture when load is set
//   load   in   capture d this cycle (deasserted while the pipe is held)
//   squash in   load an all-zero bubble; wins over load, and also acts
//               while the pipe is held so a flush can kill in place
//   q      out  registered entry
module spu_pipe_stage #(
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [EW-1:0] d,
  input  logic          load,
  input  logic          squash,
  output logic [EW-1:0] q
);

  logic [EW-1:0] ent_q;
  logic [EW-1:0] ent_d;

  always_comb begin
    ent_d = ent_q;
    if (squash)    ent_d = '0;
    else if (load) ent_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ent_q <= '0;
    else     ent_q <= ent_d;
  end

  assign q = ent_q;

endmodule

// File: rtl/spu_result_pipe.sv
// Result-staging pipeline for the SPU odd/even execution pipes.
// A result accepted on the input travels through DEPTH stage registers and
// then a registered writeback port (DEPTH+1 cycles input to wb_en).
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid/unit/data/dst/lat/wr
//                        executed result presented this cycle
//   hold                 freeze stages and writeback regs (wb_en forced low)
//   flush                drop the input and zero stages 1..FLUSH_DEPTH
//   tap_bus              every stage entry, stage i at [(i-1)*EW +: EW]
//   tap_fwd_ok           bit i-1: stage i result may be forwarded
//   wb_en/addr/data/unit registered register-file write port
//   inflight_cnt, busy   number of valid stages / any stage valid
module spu_result_pipe
  import spu_pipe_pkg::*;
#(
  parameter int DEPTH       = 7,
  parameter int DW          = 128,
  parameter int AW          = 7,
  parameter int LW          = 4,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  input  logic [2:0]                              in_unit,
  input  logic [DW-1:0]                           in_data,
  input  logic [AW-1:0]                           in_dst,
  input  logic [LW-1:0]                           in_lat,
  input  logic                                    in_wr,
  input  logic                                    hold,
  input  logic                                    flush,
  output logic [DEPTH*ENTRY_W(DW, AW, LW)-1:0]    tap_bus,
  output logic [DEPTH-1:0]                        tap_fwd_ok,
  output logic                                    wb_en,
  output logic [AW-1:0]                           wb_addr,
  output logic [DW-1:0]                           wb_data,
  output logic [2:0]                              wb_unit,
  output logic [$clog2(DEPTH+1)-1:0]              inflight_cnt,
  output logic                                    busy
);

  localparam int EW       = ENTRY_W(DW, AW, LW);
  localparam int CW       = $clog2(DEPTH + 1);
  localparam int O_DST    = OFF_DST(LW);
  localparam int O_DATA   = OFF_DATA(AW, LW);
  localparam int O_UNIT   = OFF_UNIT(DW, AW, LW);
  localparam int O_VLD    = OFF_VALID(DW, AW, LW);

  if (DEPTH < 2) begin : g_err_depth
    $error("spu_result_pipe: DEPTH must be >= 2");
  end
  if (FLUSH_DEPTH < 0 || FLUSH_DEPTH > DEPTH) begin : g_err_flush
    $error("spu_result_pipe: FLUSH_DEPTH must be within 0..DEPTH");
  end

  logic [EW-1:0] stg [1:DEPTH];
  logic [EW-1:0] in_entry;

  // Flush drops the incoming result regardless of FLUSH_DEPTH, so the
  // FLUSH_DEPTH=0 case needs no special handling in the stage array.
  assign in_entry = (in_valid && !flush) ?
                    {1'b1, in_unit, in_data, in_dst, in_lat, in_wr} : '0;

  for (genvar i = 1; i <= DEPTH; i++) begin : g_stage
    logic [EW-1:0] d;
    logic [LW-1:0] lat;

    if (i == 1) begin : g_head
      assign d = in_entry;
    end else begin : g_body
      assign d = stg[i-1];
    end

    // Squashed stages load a bubble; the stage right behind the flushed
    // window still receives its predecessor's pre-flush contents.
    spu_pipe_stage #(.EW(EW)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .d      (d),
      .load   (!hold),
      .squash (flush && (i <= FLUSH_DEPTH)),
      .q      (stg[i])
    );

    assign tap_bus[(i-1)*EW +: EW] = stg[i];

    // Stage i is i cycles past issue; latency 0 behaves like 1, and every
    // stage is at least 1 cycle old, so lat==0 is usable everywhere.
    assign lat = stg[i][OFF_LAT +: LW];
    assign tap_fwd_ok[i-1] = stg[i][O_VLD] && stg[i][OFF_WR] &&
                             ((lat == '0) || (32'(i) >= 32'(lat)));
  end

  // Occupancy (writeback register not counted).
  logic [CW-1:0] cnt;
  always_comb begin
    cnt = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      cnt = cnt + CW'(stg[k][O_VLD]);
    end
  end

  assign inflight_cnt = cnt;
  assign busy         = (cnt != '0);

  // Writeback registers. While held the entry sits in the last stage and
  // wb_en stays low, so it writes exactly once after release.
  logic          wb_en_q,   wb_en_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [2:0]    wb_unit_q, wb_unit_d;
  logic [EW-1:0] last;

  assign last = stg[DEPTH];

  always_comb begin
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wb_unit_d = wb_unit_q;
    if (!hold) begin
      wb_en_d   = last[O_VLD] & last[OFF_WR];
      wb_addr_d = last[O_DST  +: AW];
      wb_data_d = last[O_DATA +: DW];
      wb_unit_d = last[O_UNIT +: UNIT_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_unit_q <= '0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      wb_unit_q <= wb_unit_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign wb_unit = wb_unit_q;

endmodule
